sync_gp_fifo: RTL and testbench



---
 rtl/gp_fifo_pkg.sv | 9 +
 rtl/gp_fifo_mem.sv | 19 +
 rtl/sync_gp_fifo.sv | 87 ++++++++
 tb/tb_sync_gp_fifo.sv | 100 ++++++++++
 4 files changed

// File: rtl/gp_fifo_pkg.sv
// gp_fifo_pkg: pointer wrap and occupancy threshold helpers shared by the sync and async FIFOs
package gp_fifo_pkg;
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned max);
    return (ptr >= max) ? 32'd0 : ptr + 32'd1;
  endfunction
  function automatic logic thresh_hit(input int unsigned lvl, input int unsigned thr, input logic at_least);
    return at_least ? (lvl >= thr) : (lvl <= thr);
  endfunction
endpackage

// File: rtl/gp_fifo_mem.sv
// gp_fifo_mem: SLOTS x WIDTH register array with one write port and one asynchronous read port
module gp_fifo_mem #(
  parameter int SLOTS = 4,
  parameter int WIDTH = 8,
  parameter int AW = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem_q [SLOTS];
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/sync_gp_fifo.sv
// sync_gp_fifo: single-clock show-ahead FIFO of any depth with level, thresholds, flush and sticky error flags
module sync_gp_fifo
  import gp_fifo_pkg::*;
#(
  parameter int SLOTS    = 4,
  parameter int WIDTH    = 8,
  parameter int AF_LEVEL = SLOTS - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  output logic                       wr_full,
  output logic                       wr_almost_full,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_empty,
  output logic                       rd_almost_empty,
  output logic [$clog2(SLOTS+1)-1:0] level,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int PW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int LW = $clog2(SLOTS + 1);
  typedef logic [PW-1:0] ptr_t;
  typedef logic [LW-1:0] lvl_t;
  typedef logic [WIDTH-1:0] data_t;
`ifndef NO_ASSERTIONS
  if (SLOTS < 2) begin : g_bad_slots
    $error("sync_gp_fifo: SLOTS must be >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > SLOTS) begin : g_bad_af
    $error("sync_gp_fifo: AF_LEVEL must be in 1..SLOTS");
  end
  if (AE_LEVEL < 0 || AE_LEVEL >= SLOTS) begin : g_bad_ae
    $error("sync_gp_fifo: AE_LEVEL must be in 0..SLOTS-1");
  end
`endif
  ptr_t  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  lvl_t  level_q, level_d;
  logic  overflow_q, overflow_d, underflow_q, underflow_d;
  logic  wr_acc, rd_acc;
  data_t mem_rdata;
  assign wr_full         = level_q == lvl_t'(SLOTS);
  assign rd_empty        = level_q == '0;
  assign wr_almost_full  = thresh_hit(32'(level_q), unsigned'(AF_LEVEL), 1'b1);
  assign rd_almost_empty = thresh_hit(32'(level_q), unsigned'(AE_LEVEL), 1'b0);
  assign wr_acc          = wr_en & (~wr_full | rd_en);
  assign rd_acc          = rd_en & ~rd_empty;
  assign level           = level_q;
  assign overflow        = overflow_q;
  assign underflow       = underflow_q;
  assign rd_data         = mem_rdata;
  always_comb begin
    wr_ptr_d    = wr_acc ? ptr_t'(wrap_inc(32'(wr_ptr_q), unsigned'(SLOTS - 1))) : wr_ptr_q;
    rd_ptr_d    = rd_acc ? ptr_t'(wrap_inc(32'(rd_ptr_q), unsigned'(SLOTS - 1))) : rd_ptr_q;
    level_d     = (wr_acc & ~rd_acc) ? level_q + lvl_t'(1) :
                  (rd_acc & ~wr_acc) ? level_q - lvl_t'(1) : level_q;
    overflow_d  = overflow_q | (wr_en & ~wr_acc);
    underflow_d = underflow_q | (rd_en & rd_empty);
  end
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
  gp_fifo_mem #(.SLOTS(SLOTS), .WIDTH(WIDTH), .AW(PW)) u_mem (
    .clk  (clk),
    .we   (wr_acc & ~rst & ~clear),
    .waddr(wr_ptr_q),
    .wdata(wr_data),
    .raddr(rd_ptr_q),
    .rdata(mem_rdata)
  );
endmodule

// File: tb/tb_sync_gp_fifo.sv
// tb_sync_gp_fifo: scoreboard bench for sync_gp_fifo with SLOTS=5, AF_LEVEL=4, AE_LEVEL=1
module tb_sync_gp_fifo;
  localparam int SLOTS = 5;
  localparam int AF = 4;
  localparam int AE = 1;
  logic       clk = 1'b0;
  logic       rst, clear, wr_en, rd_en;
  logic [7:0] wr_data, rd_data;
  logic       wr_full, wr_almost_full, rd_empty, rd_almost_empty, overflow, underflow;
  logic [2:0] level;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  int         m_level = 0;
  logic       m_ov = 1'b0;
  logic       m_un = 1'b0;
  always #5 clk = ~clk;
  sync_gp_fifo #(.SLOTS(SLOTS), .WIDTH(8), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst(rst), .clear(clear), .wr_en(wr_en), .wr_data(wr_data),
    .wr_full(wr_full), .wr_almost_full(wr_almost_full), .rd_en(rd_en), .rd_data(rd_data),
    .rd_empty(rd_empty), .rd_almost_empty(rd_almost_empty), .level(level),
    .overflow(overflow), .underflow(underflow)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cycle(input logic w, input logic [7:0] d, input logic r, input logic c, input logic rs);
    logic wacc, racc;
    wr_en = w; wr_data = d; rd_en = r; clear = c; rst = rs;
    @(negedge clk);
    wacc = w & ((m_level != SLOTS) | r);
    racc = r & (m_level != 0);
    if (rs || c) begin
      exp_q.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
    end else begin
      if (racc) begin
        chk("pop_data", 32'(rd_data), 32'(exp_q[0]));
        void'(exp_q.pop_front());
      end
      if (wacc) exp_q.push_back(d);
      if (w && !wacc) m_ov = 1'b1;
      if (r && m_level == 0) m_un = 1'b1;
    end
    m_level = exp_q.size();
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0; rst = 1'b0;
    chk("level", 32'(level), 32'(m_level));
    chk("wr_full", 32'(wr_full), 32'(m_level == SLOTS));
    chk("rd_empty", 32'(rd_empty), 32'(m_level == 0));
    chk("almost_full", 32'(wr_almost_full), 32'(m_level >= AF));
    chk("almost_empty", 32'(rd_almost_empty), 32'(m_level <= AE));
    chk("overflow", 32'(overflow), 32'(m_ov));
    chk("underflow", 32'(underflow), 32'(m_un));
    if (m_level != 0) chk("head", 32'(rd_data), 32'(exp_q[0]));
  endtask
  task automatic wr(input logic [7:0] d);
    cycle(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic rd();
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask
  initial begin
    rst = 1'b0; clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
    @(posedge clk);
    #1;
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 5; i++) wr(8'(i * 8'h11));
    for (int i = 0; i < 5; i++) rd();
    wr(8'h00);
    for (int i = 1; i < 12; i++) cycle(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
    rd();
    for (int i = 0; i < 5; i++) wr(8'hA0 + 8'(i));
    cycle(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) rd();
    cycle(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    rd();
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) wr(8'hC0 + 8'(i));
    wr(8'hFF);
    rd();
    rd();
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) wr(8'hD0 + 8'(i));
    cycle(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) wr(8'hE0 + 8'(i));
    cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 200; i++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 29) == 0), 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
